// File: rtl/boton_evento_pkg.sv
// boton_evento_pkg
// Shared definitions for the button event classifier.
//   boton_state_e : 2-bit state encoding, also read by the mode state
//                   machine for its debug display (WAIT_REL=0, IDLE=1,
//                   PRESSED=2, LONG_HELD=3).
//   max_int       : elaboration-time helper used to size the shared counter.
package boton_evento_pkg;

    typedef enum logic [1:0] {
        WAIT_REL  = 2'd0,
        IDLE      = 2'd1,
        PRESSED   = 2'd2,
        LONG_HELD = 2'd3
    } boton_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/boton_evento.sv
// boton_evento
// Turns a debounced button level into single-cycle press events.
// A short press is reported on release, a long press when the hold reaches
// LONG_COUNT cycles; a long press never also produces a short press.
//
// Build option: define BOTON_REPEAT_EN to emit auto-repeat pulses every
// REPEAT_COUNT cycles while a long press is held. Without it repeat_pulse
// is tied low and REPEAT_COUNT only affects counter sizing.
//
// Ports
//   clk          in  : clock, rising edge
//   reset        in  : synchronous reset, active high
//   boton_in     in  : debounced level, 1 = pressed
//   short_pulse  out : one-cycle pulse on release of a short press
//   long_pulse   out : one-cycle pulse when the hold reaches LONG_COUNT
//   repeat_pulse out : one-cycle auto-repeat pulse
//   held         out : 1 while a press is tracked (PRESSED or LONG_HELD)
//
// state     | meaning
// WAIT_REL  | after reset, ignore a button that is already down
// IDLE      | button released, waiting for a press
// PRESSED   | press in progress, counting towards a long press
// LONG_HELD | long press reported, waiting for release (and repeating)
module boton_evento
    import boton_evento_pkg::*;
#(
    parameter int LONG_COUNT   = 5,
    parameter int REPEAT_COUNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int CNT_W = $clog2(max_int(LONG_COUNT, REPEAT_COUNT) + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
`ifdef BOTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
`endif

    boton_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_REL;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                WAIT_REL: begin
                    cnt_q <= '0;
                    if (!boton_in) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    cnt_q <= '0;
                    if (boton_in) begin
                        state_q <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (!boton_in) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state_q <= LONG_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (!boton_in) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
`ifdef BOTON_REPEAT_EN
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= WAIT_REL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
    // Decoded straight from the state register, so it moves in the same
    // cycle as the pulses.
    assign held         = (state_q == PRESSED) || (state_q == LONG_HELD);

endmodule
